// File: rtl/led_frame_ctrl_pkg.sv
// Shared definitions for the LED frame controller: FSM encoding, configuration
// register map and default zone boundaries.
package led_frame_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_WAIT = 2'd0,
        ST_SYNC = 2'd1,
        ST_PIX  = 2'd2
    } state_t;

    localparam logic [2:0] ADDR_COLOR0 = 3'd0;
    localparam logic [2:0] ADDR_COLOR1 = 3'd1;
    localparam logic [2:0] ADDR_COLOR2 = 3'd2;
    localparam logic [2:0] ADDR_B0     = 3'd3;
    localparam logic [2:0] ADDR_B1     = 3'd4;
    localparam logic [2:0] ADDR_CTRL   = 3'd5;

    localparam int DEFAULT_B0 = 85;
    localparam int DEFAULT_B1 = 190;

    // One complete configuration set; the shadow and active copies share this type.
    typedef struct packed {
        logic [23:0] color0;
        logic [23:0] color1;
        logic [23:0] color2;
        logic [15:0] b0;
        logic [15:0] b1;
        logic        enable;
        logic        rotate;
        logic [7:0]  step;
    } cfg_set_t;

endpackage

// File: rtl/led_zone_lookup.sv
// Combinational pixel-to-color mapping: rotates the pixel index, picks a zone
// color and reorders it into the tape's LSB-first byte-lane format.
module led_zone_lookup #(
    parameter int NUM_LEDS = 256
) (
    input  logic [15:0] num,
    input  logic [15:0] offset,
    input  logic [23:0] color0,
    input  logic [23:0] color1,
    input  logic [23:0] color2,
    input  logic [15:0] b0,
    input  logic [15:0] b1,
    output logic [23:0] rgb
);

    localparam logic [16:0] NUM_LEDS_W = 17'(NUM_LEDS);

    logic [16:0] sum;
    logic [16:0] pos;
    logic [23:0] color;

    function automatic logic [7:0] rev8(input logic [7:0] x);
        logic [7:0] r;
        for (int i = 0; i < 8; i++) begin
            r[i] = x[7-i];
        end
        return r;
    endfunction

    always_comb begin
        // Both operands are below NUM_LEDS when the result is used, so one
        // conditional subtract is a full modulo.
        sum = {1'b0, num} + {1'b0, offset};
        pos = (sum >= NUM_LEDS_W) ? sum - NUM_LEDS_W : sum;

        if (pos < {1'b0, b0}) begin
            color = color0;
        end else if (pos < {1'b0, b1}) begin
            color = color1;
        end else begin
            color = color2;
        end

        rgb = {rev8(color[7:0]), rev8(color[23:16]), rev8(color[15:8])};
    end

endmodule

// File: rtl/led_frame_ctrl.sv
// Frame controller for an addressable LED tape: double-buffered zone
// configuration, frame sequencing and registered pixel output.
module led_frame_ctrl
    import led_frame_ctrl_pkg::*;
#(
    parameter int NUM_LEDS = 256,
    parameter int DEF_B0   = DEFAULT_B0,
    parameter int DEF_B1   = DEFAULT_B1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req,
    input  logic        sync,
    input  logic [15:0] num,
    output logic [23:0] rgb,
    input  logic        cfg_valid,
    output logic        cfg_ready,
    input  logic [2:0]  cfg_addr,
    input  logic [23:0] cfg_data,
    output logic        frame_start,
    output logic [15:0] frame_cnt
);

    localparam logic [16:0] NUM_LEDS_W = 17'(NUM_LEDS);
    localparam logic [15:0] MAX_IDX    = 16'(NUM_LEDS - 1);

    localparam cfg_set_t CFG_RESET = '{
        color0: 24'h0,
        color1: 24'h0,
        color2: 24'h0,
        b0:     16'(DEF_B0),
        b1:     16'(DEF_B1),
        enable: 1'b0,
        rotate: 1'b0,
        step:   8'd1
    };

    state_t      state;
    cfg_set_t    shadow;
    cfg_set_t    active;
    logic [15:0] offset;

    logic        commit;
    logic        to_pix;
    logic        wr_en;
    logic [15:0] step_lim;
    logic [16:0] offset_sum;
    logic [15:0] offset_next;
    logic [23:0] zone_rgb;
    logic [23:0] rgb_next;

    // NOTE: every variable gets a value on every path through this block, so no latches.
    always_comb begin
        commit      = ~reset & req & sync & (state != ST_SYNC);
        to_pix      = req & ~sync & (state == ST_SYNC);
        // Writes are held off during a commit so shadow and active never race.
        cfg_ready   = ~reset & ~commit;
        wr_en       = cfg_valid & cfg_ready;

        step_lim    = ({8'd0, active.step} > MAX_IDX) ? MAX_IDX : {8'd0, active.step};
        offset_sum  = {1'b0, offset} + {1'b0, step_lim};
        offset_next = (offset_sum >= NUM_LEDS_W) ? 16'(offset_sum - NUM_LEDS_W)
                                                 : offset_sum[15:0];

        if (state == ST_WAIT || sync || !active.enable || {1'b0, num} >= NUM_LEDS_W) begin
            rgb_next = '0;
        end else begin
            rgb_next = zone_rgb;
        end
    end

    led_zone_lookup #(
        .NUM_LEDS (NUM_LEDS)
    ) u_zone_lookup (
        .num    (num),
        .offset (offset),
        .color0 (active.color0),
        .color1 (active.color1),
        .color2 (active.color2),
        .b0     (active.b0),
        .b1     (active.b1),
        .rgb    (zone_rgb)
    );

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= ST_WAIT;
            rgb         <= '0;
            frame_start <= 1'b0;
            frame_cnt   <= '0;
            offset      <= '0;
        end else begin
            frame_start <= to_pix;
            if (to_pix) begin
                frame_cnt <= frame_cnt + 16'd1;
                if (active.rotate) begin
                    offset <= offset_next;
                end
            end
            if (req) begin
                rgb <= rgb_next;
            end
            case (state)
                ST_WAIT, ST_PIX: if (req && sync)  state <= ST_SYNC;
                ST_SYNC:         if (req && !sync) state <= ST_PIX;
                default:         state <= ST_WAIT;
            endcase
        end
    end

    // NOTE: both configuration copies are reset, so a commit before any write is well defined.
    always_ff @(posedge clk) begin
        if (reset) begin
            shadow <= CFG_RESET;
            active <= CFG_RESET;
        end else begin
            if (wr_en) begin
                case (cfg_addr)
                    ADDR_COLOR0: shadow.color0 <= cfg_data;
                    ADDR_COLOR1: shadow.color1 <= cfg_data;
                    ADDR_COLOR2: shadow.color2 <= cfg_data;
                    ADDR_B0:     shadow.b0     <= cfg_data[15:0];
                    ADDR_B1:     shadow.b1     <= cfg_data[15:0];
                    ADDR_CTRL: begin
                        shadow.enable <= cfg_data[0];
                        shadow.rotate <= cfg_data[1];
                        shadow.step   <= cfg_data[15:8];
                    end
                    default: ;
                endcase
            end
            if (commit) begin
                active <= shadow;
            end
        end
    end

endmodule

// File: tb/tb_led_frame_ctrl.sv
// Directed bench for led_frame_ctrl: a reference model predicts each cycle's
// outputs into a scoreboard queue that is drained after the clock edge.
module tb_led_frame_ctrl;
    import led_frame_ctrl_pkg::*;

    localparam int N = 256;

    logic        clk = 1'b0;
    logic        reset;
    logic        req;
    logic        sync;
    logic [15:0] num;
    logic [23:0] rgb;
    logic        cfg_valid;
    logic        cfg_ready;
    logic [2:0]  cfg_addr;
    logic [23:0] cfg_data;
    logic        frame_start;
    logic [15:0] frame_cnt;

    int vecs = 0;
    int miscompares = 0;
    logic [23:0] exp_q[$];

    // Reference model state.
    logic [23:0] sh_c[3];
    logic [23:0] ac_c[3];
    int          sh_b0, sh_b1, sh_step, ac_b0, ac_b1, ac_step;
    logic        sh_en, sh_rot, ac_en, ac_rot;
    int          m_state;   // 0 wait, 1 sync, 2 pix
    int          m_off;
    logic [15:0] m_cnt;
    logic [23:0] m_rgb;

    always #5 clk = ~clk;

    led_frame_ctrl #(
        .NUM_LEDS (N),
        .DEF_B0   (85),
        .DEF_B1   (190)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .req         (req),
        .sync        (sync),
        .num         (num),
        .rgb         (rgb),
        .cfg_valid   (cfg_valid),
        .cfg_ready   (cfg_ready),
        .cfg_addr    (cfg_addr),
        .cfg_data    (cfg_data),
        .frame_start (frame_start),
        .frame_cnt   (frame_cnt)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        vecs++;
        assert (obs === exp_v) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
        end
    endtask

    function automatic logic [7:0] rev(input logic [7:0] x);
        logic [7:0] y;
        y = {<<{x}};
        return y;
    endfunction

    function automatic logic [23:0] exp_pixel(input int n, input logic s);
        int p;
        logic [23:0] c;
        if (m_state == 0 || s || !ac_en || n >= N) return 24'h0;
        p = (n + m_off) % N;
        if (p < ac_b0)      c = ac_c[0];
        else if (p < ac_b1) c = ac_c[1];
        else                c = ac_c[2];
        return {rev(c[7:0]), rev(c[23:16]), rev(c[15:8])};
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 3; i++) begin
            sh_c[i] = 24'h0;
            ac_c[i] = 24'h0;
        end
        sh_b0 = 85;  ac_b0 = 85;
        sh_b1 = 190; ac_b1 = 190;
        sh_en = 0;   ac_en = 0;
        sh_rot = 0;  ac_rot = 0;
        sh_step = 1; ac_step = 1;
        m_state = 0; m_off = 0; m_cnt = 16'd0; m_rgb = 24'h0;
    endtask

    task automatic model_write(input logic [2:0] a, input logic [23:0] d);
        case (a)
            3'd0, 3'd1, 3'd2: sh_c[a] = d;
            3'd3: sh_b0 = int'(d[15:0]);
            3'd4: sh_b1 = int'(d[15:0]);
            3'd5: begin
                sh_en   = d[0];
                sh_rot  = d[1];
                sh_step = int'(d[15:8]);
            end
            default: ;
        endcase
    endtask

    // One clock cycle: drive, predict, advance, compare.
    task automatic cycle(input logic r, input logic s, input int n, input logic cv,
                         input logic [2:0] a, input logic [23:0] d, output logic acc);
        logic commit, to_pix;
        req = r; sync = s; num = 16'(n);
        cfg_valid = cv; cfg_addr = a; cfg_data = d;
        commit = r && s && m_state != 1;
        to_pix = r && !s && m_state == 1;
        #1;
        chk("cfg_ready", {31'd0, cfg_ready}, {31'd0, !commit});
        acc = cv && !commit;
        if (r) m_rgb = exp_pixel(n, s);
        exp_q.push_back(m_rgb);
        if (acc) model_write(a, d);
        if (commit) begin
            ac_c = sh_c; ac_b0 = sh_b0; ac_b1 = sh_b1;
            ac_en = sh_en; ac_rot = sh_rot; ac_step = sh_step;
        end
        if (to_pix) begin
            m_cnt++;
            if (ac_rot) m_off = (m_off + ((ac_step < N - 1) ? ac_step : N - 1)) % N;
        end
        if (r && s) m_state = 1;
        else if (to_pix) m_state = 2;
        @(posedge clk);
        #1;
        chk("rgb", {8'd0, rgb}, {8'd0, exp_q.pop_front()});
        chk("frame_start", {31'd0, frame_start}, {31'd0, to_pix});
        chk("frame_cnt", {16'd0, frame_cnt}, {16'd0, m_cnt});
    endtask

    task automatic pix(input int n);
        logic acc;
        cycle(1'b1, 1'b0, n, 1'b0, 3'd0, 24'h0, acc);
    endtask

    task automatic syn();
        logic acc;
        cycle(1'b1, 1'b1, 0, 1'b0, 3'd0, 24'h0, acc);
    endtask

    task automatic cfg_write(input logic [2:0] a, input logic [23:0] d);
        logic acc = 1'b0;
        for (int i = 0; i < 4 && !acc; i++) cycle(1'b0, 1'b0, 0, 1'b1, a, d, acc);
    endtask

    // Reset is applied together with req and a config write to exercise its priority.
    task automatic do_reset(input logic r, input int n);
        reset = 1'b1; req = r; sync = 1'b0; num = 16'(n);
        cfg_valid = 1'b1; cfg_addr = ADDR_COLOR0; cfg_data = 24'hFFFFFF;
        @(posedge clk);
        #1;
        chk("rst_rgb", {8'd0, rgb}, 32'd0);
        chk("rst_frame_start", {31'd0, frame_start}, 32'd0);
        chk("rst_frame_cnt", {16'd0, frame_cnt}, 32'd0);
        chk("rst_cfg_ready", {31'd0, cfg_ready}, 32'd0);
        @(posedge clk);
        #1;
        reset = 1'b0; req = 1'b0; cfg_valid = 1'b0;
        model_reset();
        exp_q.delete();
    endtask

    function automatic logic [23:0] s1_color(input int n);
        if (n < 85)  return 24'h00FF00;
        if (n < 190) return 24'h0000FF;
        return 24'hFF0000;
    endfunction

    initial begin : watchdog
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        logic acc;
        logic [15:0] cnt_before;
        int seen0, seen1, seen2;

        // Reset and basic three-zone frame.
        do_reset(1'b1, 0);
        cfg_write(ADDR_COLOR0, 24'hFF0000);
        cfg_write(ADDR_COLOR1, 24'h00FF00);
        cfg_write(ADDR_COLOR2, 24'h0000FF);
        cfg_write(ADDR_CTRL,   24'h000001);
        pix(10);
        chk("s1_wait_zero", {8'd0, rgb}, 32'd0);
        syn();
        chk("s1_sync_zero", {8'd0, rgb}, 32'd0);
        syn();
        for (int n = 0; n < N; n++) begin
            pix(n);
            chk("s1_pix", {8'd0, rgb}, {8'd0, s1_color(n)});
        end
        syn();
        chk("s1_sync_end", {8'd0, rgb}, 32'd0);

        // Mid-frame color0 write only takes effect next frame.
        for (int n = 0; n < 10; n++) pix(n);
        cfg_write(ADDR_COLOR0, 24'h123456);
        for (int n = 10; n <= 20; n++) begin
            pix(n);
            chk("s2_unchanged", {8'd0, rgb}, 32'h0000FF00);
        end
        syn();
        pix(0);
        chk("s2_new_color", {8'd0, rgb}, 32'h006A482C);

        // Write colliding with the PIX->SYNC commit.
        pix(1);
        cycle(1'b1, 1'b1, 0, 1'b1, ADDR_COLOR0, 24'hFF0000, acc);
        cycle(1'b1, 1'b1, 0, 1'b1, ADDR_COLOR0, 24'hFF0000, acc);
        pix(0);
        chk("s3_still_old", {8'd0, rgb}, 32'h006A482C);
        for (int n = 1; n < 4; n++) pix(n);
        syn();
        pix(0);
        chk("s3_applied", {8'd0, rgb}, 32'h0000FF00);

        // Rotation. The step field is 8 bits, so 255 is the largest step that can be
        // written; with NUM_LEDS=256 it is also the saturated step.
        cfg_write(ADDR_CTRL, 24'h00FF03);
        cnt_before = frame_cnt;
        syn();
        pix(0);
        pix(1);
        chk("s4_a_px1", {8'd0, rgb}, 32'h0000FF00);
        syn();
        pix(0);
        chk("s4_b_px0", {8'd0, rgb}, 32'h00FF0000);
        pix(1);
        chk("s4_b_px1", {8'd0, rgb}, 32'h00FF0000);
        pix(2);
        chk("s4_b_px2", {8'd0, rgb}, 32'h0000FF00);
        syn();
        for (int n = 0; n < 6; n++) pix(n);
        chk("s4_frame_delta", {16'd0, 16'(frame_cnt - cnt_before)}, 32'd3);

        // Inverted boundaries: zone 1 is empty.
        cfg_write(ADDR_B0,   24'd200);
        cfg_write(ADDR_B1,   24'd100);
        cfg_write(ADDR_CTRL, 24'h000101);
        syn();
        seen0 = 0; seen1 = 0; seen2 = 0;
        for (int n = 0; n < N; n++) begin
            pix(n);
            if (rgb === 24'h00FF00) seen0++;
            if (rgb === 24'h0000FF) seen1++;
            if (rgb === 24'hFF0000) seen2++;
        end
        chk("s5_zone0_count", seen0, 32'd200);
        chk("s5_zone1_count", seen1, 32'd0);
        chk("s5_zone2_count", seen2, 32'd56);
        pix(300);
        chk("s5_out_of_range", {8'd0, rgb}, 32'd0);

        // Reset in the middle of PIX.
        pix(5);
        do_reset(1'b1, 5);
        cfg_write(ADDR_COLOR1, 24'h00FF00);
        cfg_write(ADDR_CTRL,   24'h000001);
        pix(100);
        chk("s6_wait_zero", {8'd0, rgb}, 32'd0);
        syn();
        chk("s6_sync_zero", {8'd0, rgb}, 32'd0);
        pix(100);
        chk("s6_resume", {8'd0, rgb}, 32'h000000FF);
        pix(0);
        chk("s6_color0_not_written", {8'd0, rgb}, 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vecs, miscompares);
        $finish;
    end

endmodule
